stream_minmax_tracker: RTL

//  Downstream consumer of the 16-bit cascaded magnitude compare. Accepts a

---
 rtl/stream_minmax_tracker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/stream_minmax_tracker.sv
// Frame-based running min/max tracker over a valid/ready sample stream.
// Two cascaded 16-bit magnitude comparators decide min/max updates; one result per frame.

module hexcomparator (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        l_in,
    input  logic        e_in,
    input  logic        g_in,
    output logic        l_out,
    output logic        e_out,
    output logic        g_out
);
    logic [4:0] l_c;
    logic [4:0] e_c;
    logic [4:0] g_c;

    assign l_c[0] = l_in;
    assign e_c[0] = e_in;
    assign g_c[0] = g_in;

    // Walk nibbles from least to most significant; a differing higher nibble overrides.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            logic [3:0] a_nib;
            logic [3:0] b_nib;
            assign a_nib = a[gi*4 +: 4];
            assign b_nib = b[gi*4 +: 4];
            assign l_c[gi+1] = (a_nib < b_nib) | ((a_nib == b_nib) & l_c[gi]);
            assign e_c[gi+1] = (a_nib == b_nib) & e_c[gi];
            assign g_c[gi+1] = (a_nib > b_nib) | ((a_nib == b_nib) & g_c[gi]);
        end
    endgenerate

    assign l_out = l_c[4];
    assign e_out = e_c[4];
    assign g_out = g_c[4];
endmodule

module stream_minmax_tracker #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_min,
    output logic [15:0]        out_max,
    output logic [COUNT_W-1:0] out_min_idx,
    output logic [COUNT_W-1:0] out_max_idx,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_sat
);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        min_reg, min_next;
    logic [15:0]        max_reg, max_next;
    logic [COUNT_W-1:0] min_idx_reg, min_idx_next;
    logic [COUNT_W-1:0] max_idx_reg, max_idx_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               sat_reg, sat_next;
    logic               out_valid_reg, out_valid_next;

    logic accept;
    logic min_lt, min_eq, min_gt;
    logic max_lt, max_eq, max_gt;
    logic min_take, max_take;

    assign in_ready = !rst && (state_reg != DONE);
    assign accept   = in_valid && in_ready;

    hexcomparator u_cmp_min (
        .a(in_data), .b(min_reg),
        .l_in(1'b0), .e_in(1'b1), .g_in(1'b0),
        .l_out(min_lt), .e_out(min_eq), .g_out(min_gt)
    );

    hexcomparator u_cmp_max (
        .a(in_data), .b(max_reg),
        .l_in(1'b0), .e_in(1'b1), .g_in(1'b0),
        .l_out(max_lt), .e_out(max_eq), .g_out(max_gt)
    );

    // Strict L/G only: equal samples keep the first recorded index.
    assign min_take = min_lt && !(min_eq || min_gt);
    assign max_take = max_gt && !(max_eq || max_lt);

    always_comb begin
        state_next   = state_reg;
        min_next     = min_reg;
        max_next     = max_reg;
        min_idx_next = min_idx_reg;
        max_idx_next = max_idx_reg;
        count_next   = count_reg;
        sat_next     = sat_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    min_next     = in_data;
                    max_next     = in_data;
                    min_idx_next = '0;
                    max_idx_next = '0;
                    count_next   = {{(COUNT_W-1){1'b0}}, 1'b1};
                    sat_next     = 1'b0;
                    state_next   = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // count_reg is the 0-based index of this sample, pinned at CNT_MAX once saturated.
                    if (min_take) begin
                        min_next     = in_data;
                        min_idx_next = count_reg;
                    end
                    if (max_take) begin
                        max_next     = in_data;
                        max_idx_next = count_reg;
                    end
                    if (count_reg == CNT_MAX) begin
                        sat_next = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        out_valid_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            min_reg       <= '0;
            max_reg       <= '0;
            min_idx_reg   <= '0;
            max_idx_reg   <= '0;
            count_reg     <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            min_reg       <= min_next;
            max_reg       <= max_next;
            min_idx_reg   <= min_idx_next;
            max_idx_reg   <= max_idx_next;
            count_reg     <= count_next;
            sat_reg       <= sat_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_min     = min_reg;
    assign out_max     = max_reg;
    assign out_min_idx = min_idx_reg;
    assign out_max_idx = max_idx_reg;
    assign out_count   = count_reg;
    assign out_sat     = sat_reg;
endmodule
